demux14_reg: RTL and testbench

Registered 1-to-4 demultiplexer: the distributing end of the board's 4-to-1 selector path. Accepts one DATA_LEN-bit word per valid/ready handshake and writes it into one of four output registers, chosen by an explicit select or by an internal round-robin pointer. Each channel carries a "fresh" flag that the consumer acknowledges, which gives back-pressure to the source. Sits between switch/LED-level stimulus logic and downstream per-channel consumers on the NVBoard designs.

---
 rtl/demux14_reg_if.sv | 34 +++
 rtl/demux14_reg.sv | 101 ++++++++++
 tb/tb_demux14_reg.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/demux14_reg_if.sv
// demux14_reg_if
// Bundles the source handshake, the per-channel consumer signals and the
// status outputs of demux14_reg.
//   master : source / consumer side (drives din, sel, auto, in_valid, clr,
//            out_ack; observes in_ready, f0..f3, fresh, ptr, overrun)
//   slave  : the demultiplexer itself
interface demux14_reg_if #(
  parameter int DATA_LEN = 2
);
  logic [DATA_LEN-1:0] din;
  logic [1:0]          sel;
  logic                auto;
  logic                in_valid;
  logic                in_ready;
  logic                clr;
  logic [3:0]          out_ack;
  logic [DATA_LEN-1:0] f0;
  logic [DATA_LEN-1:0] f1;
  logic [DATA_LEN-1:0] f2;
  logic [DATA_LEN-1:0] f3;
  logic [3:0]          fresh;
  logic [1:0]          ptr;
  logic                overrun;

  modport master (
    output din, sel, auto, in_valid, clr, out_ack,
    input  in_ready, f0, f1, f2, f3, fresh, ptr, overrun
  );

  modport slave (
    input  din, sel, auto, in_valid, clr, out_ack,
    output in_ready, f0, f1, f2, f3, fresh, ptr, overrun
  );
endinterface

// File: rtl/demux14_reg.sv
// demux14_reg
// Registered 1-to-4 demultiplexer. One DATA_LEN-bit word is accepted per
// valid/ready handshake and stored in the channel chosen by sel (auto = 0)
// or by the round-robin pointer ptr (auto = 1). Each channel has a fresh
// flag that the consumer clears with out_ack; a fresh, un-acked target
// channel holds off the source.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : demux14_reg_if.slave (din, sel, auto, in_valid, in_ready, clr,
//          out_ack, f0..f3, fresh, ptr, overrun)
// Optional build macro:
//   DEMUX14_OVERWRITE_EN : removes back-pressure; writing a fresh, un-acked
//                          channel overwrites it and sets the sticky overrun.
//                          Without it, overrun is tied low.
module demux14_reg #(
  parameter int DATA_LEN = 2
) (
  input  logic          clk,
  input  logic          rst,
  demux14_reg_if.slave  bus
);

  logic [DATA_LEN-1:0] r_chan [4];
  logic [3:0]          r_fresh;
  logic [1:0]          r_ptr;

  logic [1:0]          w_tgt;
  logic                w_ready;
  logic                w_accept;
  logic [3:0]          w_wrMask;
  logic [3:0]          w_freshNext;

  // Target selection and handshake. Ready never looks at din or in_valid,
  // so the source may wait for ready before raising valid.
  always_comb begin
    w_tgt = bus.auto ? r_ptr : bus.sel;
`ifdef DEMUX14_OVERWRITE_EN
    w_ready = !bus.clr;
`else
    w_ready = !bus.clr && (!r_fresh[w_tgt] || bus.out_ack[w_tgt]);
`endif
    w_accept = bus.in_valid && w_ready;
    w_wrMask = w_accept ? (4'b0001 << w_tgt) : 4'b0000;
    // A write to a channel wins over its ack: the ack consumed the old word.
    w_freshNext = (r_fresh & ~bus.out_ack) | w_wrMask;
  end

  // Channel registers: only the target channel is written on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) r_chan[n] <= '0;
    end else if (bus.clr) begin
      for (int n = 0; n < 4; n++) r_chan[n] <= '0;
    end else if (w_accept) begin
      r_chan[w_tgt] <= bus.din;
    end
  end

  // Fresh flags and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fresh <= 4'b0000;
      r_ptr   <= 2'd0;
    end else if (bus.clr) begin
      r_fresh <= 4'b0000;
      r_ptr   <= 2'd0;
    end else begin
      r_fresh <= w_freshNext;
      if (w_accept && bus.auto) r_ptr <= r_ptr + 2'd1;
    end
  end

`ifdef DEMUX14_OVERWRITE_EN
  logic r_overrun;

  // Sticky flag: set when an accepted word lands on unconsumed data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (bus.clr) begin
      r_overrun <= 1'b0;
    end else if (w_accept && r_fresh[w_tgt] && !bus.out_ack[w_tgt]) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.overrun = r_overrun;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.in_ready = w_ready;
  assign bus.f0       = r_chan[0];
  assign bus.f1       = r_chan[1];
  assign bus.f2       = r_chan[2];
  assign bus.f3       = r_chan[3];
  assign bus.fresh    = r_fresh;
  assign bus.ptr      = r_ptr;

endmodule

// File: tb/tb_demux14_reg.sv
// tb_demux14_reg
// Table-driven bench for demux14_reg: each record holds the inputs applied
// for one cycle, the expected in_ready during that cycle, and the expected
// registered state after the following rising edge. Reset behaviour is
// exercised by hand-written sequences.
module tb_demux14_reg;

  typedef struct {
    logic [1:0] din;
    logic [1:0] sel;
    logic       autoMode;
    logic       valid;
    logic       clr;
    logic [3:0] ack;
    logic       expReady;
    logic [1:0] expF0;
    logic [1:0] expF1;
    logic [1:0] expF2;
    logic [1:0] expF3;
    logic [3:0] expFresh;
    logic [1:0] expPtr;
    logic       expOvr;
  } vec_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  vec_t vecs[$];

  demux14_reg_if #(.DATA_LEN(2)) bus ();

  demux14_reg #(.DATA_LEN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic [1:0] din, input logic [1:0] sel,
                        input logic a, input logic v, input logic c,
                        input logic [3:0] ack, input logic rdy,
                        input logic [1:0] e0, input logic [1:0] e1,
                        input logic [1:0] e2, input logic [1:0] e3,
                        input logic [3:0] fr, input logic [1:0] p,
                        input logic ov);
    vec_t t;
    t.din = din; t.sel = sel; t.autoMode = a; t.valid = v; t.clr = c;
    t.ack = ack; t.expReady = rdy; t.expF0 = e0; t.expF1 = e1;
    t.expF2 = e2; t.expF3 = e3; t.expFresh = fr; t.expPtr = p; t.expOvr = ov;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    bus.din      = t.din;
    bus.sel      = t.sel;
    bus.auto     = t.autoMode;
    bus.in_valid = t.valid;
    bus.clr      = t.clr;
    bus.out_ack  = t.ack;
  endtask

  task automatic checkState(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                            input logic [1:0] e2, input logic [1:0] e3,
                            input logic [3:0] fr, input logic [1:0] p, input logic ov);
    checkOutput({tag, " f0"}, int'(bus.f0), int'(e0));
    checkOutput({tag, " f1"}, int'(bus.f1), int'(e1));
    checkOutput({tag, " f2"}, int'(bus.f2), int'(e2));
    checkOutput({tag, " f3"}, int'(bus.f3), int'(e3));
    checkOutput({tag, " fresh"}, int'(bus.fresh), int'(fr));
    checkOutput({tag, " ptr"}, int'(bus.ptr), int'(p));
    checkOutput({tag, " overrun"}, int'(bus.overrun), int'(ov));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst          = 1'b1;
    bus.din      = 2'd0;
    bus.sel      = 2'd0;
    bus.auto     = 1'b0;
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
    bus.out_ack  = 4'b0000;

    //       din sel a v c ack     rdy f0 f1 f2 f3 fresh   ptr ov
`ifdef DEMUX14_OVERWRITE_EN
    addVec(2'd1, 2'd1, 0, 1, 0, 4'b0000, 1, 0, 1, 0, 0, 4'b0010, 0, 0);
    addVec(2'd2, 2'd1, 0, 1, 0, 4'b0000, 1, 0, 2, 0, 0, 4'b0010, 0, 1);
    addVec(2'd0, 2'd1, 0, 0, 0, 4'b0010, 1, 0, 2, 0, 0, 4'b0000, 0, 1);
    addVec(2'd3, 2'd2, 0, 1, 0, 4'b0000, 1, 0, 2, 3, 0, 4'b0100, 0, 1);
    addVec(2'd1, 2'd2, 0, 1, 0, 4'b0100, 1, 0, 2, 1, 0, 4'b0100, 0, 1);
    addVec(2'd3, 2'd2, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    addVec(2'd1, 2'd2, 0, 1, 0, 4'b0000, 1, 0, 0, 1, 0, 4'b0100, 0, 0);
    addVec(2'd2, 2'd2, 0, 1, 0, 4'b0100, 1, 0, 0, 2, 0, 4'b0100, 0, 0);
`else
    // explicit routing, then clr with a pending write
    addVec(2'd3, 2'd2, 0, 1, 0, 4'b0000, 1, 0, 0, 3, 0, 4'b0100, 0, 0);
    addVec(2'd1, 2'd0, 0, 1, 0, 4'b0000, 1, 1, 0, 3, 0, 4'b0101, 0, 0);
    addVec(2'd2, 2'd1, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    // round-robin fill, back-pressure, release by ack on the same edge
    addVec(2'd0, 2'd0, 1, 1, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0001, 1, 0);
    addVec(2'd1, 2'd0, 1, 1, 0, 4'b0000, 1, 0, 1, 0, 0, 4'b0011, 2, 0);
    addVec(2'd2, 2'd0, 1, 1, 0, 4'b0000, 1, 0, 1, 2, 0, 4'b0111, 3, 0);
    addVec(2'd3, 2'd0, 1, 1, 0, 4'b0000, 1, 0, 1, 2, 3, 4'b1111, 0, 0);
    addVec(2'd0, 2'd0, 1, 1, 0, 4'b0000, 0, 0, 1, 2, 3, 4'b1111, 0, 0);
    addVec(2'd3, 2'd0, 1, 1, 0, 4'b0000, 0, 0, 1, 2, 3, 4'b1111, 0, 0);
    addVec(2'd0, 2'd0, 1, 1, 0, 4'b0001, 1, 0, 1, 2, 3, 4'b1111, 1, 0);
    // same-edge write and ack on channel 3, then plain acks
    addVec(2'd1, 2'd3, 0, 1, 0, 4'b1000, 1, 0, 1, 2, 1, 4'b1111, 1, 0);
    addVec(2'd2, 2'd3, 0, 1, 0, 4'b1000, 1, 0, 1, 2, 2, 4'b1111, 1, 0);
    addVec(2'd0, 2'd3, 0, 0, 0, 4'b1000, 1, 0, 1, 2, 2, 4'b0111, 1, 0);
    addVec(2'd0, 2'd3, 0, 0, 0, 4'b1000, 1, 0, 1, 2, 2, 4'b0111, 1, 0);
    addVec(2'd1, 2'd3, 0, 1, 0, 4'b0010, 1, 0, 1, 2, 1, 4'b1101, 1, 0);
    // reach fresh = 1111, ptr = 2, then clr beats write and acks
    addVec(2'd2, 2'd0, 1, 1, 0, 4'b0000, 1, 0, 2, 2, 1, 4'b1111, 2, 0);
    addVec(2'd3, 2'd0, 1, 1, 1, 4'b1111, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    // switching sel/auto while valid stays high
    addVec(2'd2, 2'd1, 0, 1, 0, 4'b0000, 1, 0, 2, 0, 0, 4'b0010, 0, 0);
    addVec(2'd3, 2'd1, 1, 1, 0, 4'b0000, 1, 3, 2, 0, 0, 4'b0011, 1, 0);
    addVec(2'd1, 2'd2, 0, 1, 0, 4'b0000, 1, 3, 2, 1, 0, 4'b0111, 1, 0);
    addVec(2'd0, 2'd1, 0, 1, 0, 4'b0000, 0, 3, 2, 1, 0, 4'b0111, 1, 0);
`endif

    // Power-on reset: state is cleared while rst is still high.
    #3;
    checkState("por", 0, 0, 0, 0, 4'b0000, 0, 0);
    checkOutput("por in_ready", int'(bus.in_ready), 1);
    #9 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), int'(bus.in_ready), int'(vecs[i].expReady));
      @(posedge clk);
      #1;
      checkState($sformatf("vec%0d", i), vecs[i].expF0, vecs[i].expF1, vecs[i].expF2,
                 vecs[i].expF3, vecs[i].expFresh, vecs[i].expPtr, vecs[i].expOvr);
    end

    // Mid-stream asynchronous reset: a pending write to channel 3 must be
    // dropped, and state clears without waiting for a clock edge.
    @(negedge clk);
    bus.din      = 2'd2;
    bus.sel      = 2'd3;
    bus.auto     = 1'b0;
    bus.in_valid = 1'b1;
    bus.clr      = 1'b0;
    bus.out_ack  = 4'b0000;
    #2 rst = 1'b1;
    #1;
    checkState("async rst", 0, 0, 0, 0, 4'b0000, 0, 0);
    checkOutput("async rst in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    checkState("rst held", 0, 0, 0, 0, 4'b0000, 0, 0);
    #2 rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkState("after rst", 0, 0, 0, 0, 4'b0000, 0, 0);

    // First write after reset lands normally.
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    checkState("post rst write", 0, 0, 0, 2, 4'b1000, 0, 0);
    bus.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
